// File: rtl/nonarch_pipe_reg.sv
// nonarch_pipe_reg: elastic valid/ready register chain of DEPTH stages with bubble collapse.
// Latency: a word accepted at edge N is on o_y with o_valid=1 after edge N+DEPTH-1. Sustains one word per cycle.
// Backpressure: a full chain with i_ready=0 holds every stage. The only combinational input-to-output path is i_ready -> o_ready.
//
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_flush             drops every in-flight word; data registers keep their contents
//   i_valid/o_ready/i_x upstream handshake and data into stage 0
//   o_valid/i_ready/o_y downstream handshake and data from stage DEPTH-1 (o_y comes straight from a register)
//   o_count             number of valid stages, registered
module nonarch_pipe_reg #(
  parameter int                WIDTH     = 32,
  parameter int                DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_x,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_y,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] adv;    // stage k hands its word to k+1 (or to downstream) this edge
  logic [DEPTH-1:0] load;   // stage k receives a word this edge
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             accept;

  // The advance chain is resolved from the output end backwards, so a stall at the last stage
  // ripples toward stage 0 only through valid stages. An invalid successor always lets its
  // predecessor move, which is what collapses bubbles regardless of i_ready.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = vld_q[DEPTH-1] & i_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = vld_q[k] & (~vld_q[k+1] | adv[k+1]);
    end
  end

  assign o_ready = ~vld_q[0] | adv[0];

  // A word offered during a flush is never captured, even though o_ready may be high.
  assign accept = i_valid & o_ready & ~i_flush;

  always_comb begin
    load = '0;
    load[0] = accept;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1];
    end
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (i_flush) begin
      // Only the valid flags are cleared; data registers keep their last contents.
      vld_d = '0;
    end else begin
      // A stage that both hands off and receives in the same edge stays valid.
      vld_d = (vld_q & ~adv) | load;
      if (load[0]) begin
        data_d[0] = i_x;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          data_d[k] = data_q[k-1];
        end
      end
    end
  end

  // The occupancy is counted from the next-state flags so o_count can be a plain register
  // that always agrees with the flags after the same edge.
  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_d = cnt_d + CW'(vld_d[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign o_valid = vld_q[DEPTH-1];
  assign o_y     = data_q[DEPTH-1];
  assign o_count = cnt_q;

endmodule

// File: tb/tb_nonarch_pipe_reg.sv
// tb_nonarch_pipe_reg: checks three builds of nonarch_pipe_reg (DEPTH 2/1/8) against a position-based model.
// Latency: directed sequences for DEPTH=2, then 10000 random cycles on all three builds together.
// Backpressure: random i_ready per build; the DEPTH=2 build also sees occasional flushes.
module tb_nonarch_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vin [3];
  logic        rin [3];
  logic        fl  [3];
  logic [63:0] xin [3];

  logic        a_ordy, a_ovld;
  logic [31:0] a_y;
  logic [1:0]  a_cnt;
  logic        b_ordy, b_ovld;
  logic [15:0] b_y;
  logic [0:0]  b_cnt;
  logic        c_ordy, c_ovld;
  logic [63:0] c_y;
  logic [3:0]  c_cnt;

  nonarch_pipe_reg #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'hDEADBEEF)) u_a (
    .i_clk(clk), .i_rst(rst), .i_flush(fl[0]), .i_valid(vin[0]), .o_ready(a_ordy),
    .i_x(xin[0][31:0]), .o_valid(a_ovld), .i_ready(rin[0]), .o_y(a_y), .o_count(a_cnt));

  nonarch_pipe_reg #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h5A5A)) u_b (
    .i_clk(clk), .i_rst(rst), .i_flush(fl[1]), .i_valid(vin[1]), .o_ready(b_ordy),
    .i_x(xin[1][15:0]), .o_valid(b_ovld), .i_ready(rin[1]), .o_y(b_y), .o_count(b_cnt));

  nonarch_pipe_reg #(.WIDTH(64), .DEPTH(8), .RESET_VAL(64'h0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_flush(fl[2]), .i_valid(vin[2]), .o_ready(c_ordy),
    .i_x(xin[2]), .o_valid(c_ovld), .i_ready(rin[2]), .o_y(c_y), .o_count(c_cnt));

  int tests = 0;
  int fails = 0;
  bit armed = 0;

  int          dep   [3] = '{2, 1, 8};
  logic [63:0] rval  [3] = '{64'hDEADBEEF, 64'h5A5A, 64'h0};
  logic [63:0] wmask [3] = '{64'hFFFF_FFFF, 64'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  // Model: the words in flight, oldest first, each with the stage index it occupies.
  logic [63:0] m_dat  [3][8];
  int          m_pos  [3][8];
  int          m_n    [3];
  logic [63:0] m_y    [3];
  bit          m_ordy [3];
  int          mv_pos [8];
  bit          mv_pop;

  logic [63:0] sbq1 [$];
  logic [63:0] sbq2 [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic get_out(input int id, output logic r, output logic v,
                         output logic [63:0] y, output logic [63:0] c);
    case (id)
      0:       begin r = a_ordy; v = a_ovld; y = 64'(a_y); c = 64'(a_cnt); end
      1:       begin r = b_ordy; v = b_ovld; y = 64'(b_y); c = 64'(b_cnt); end
      default: begin r = c_ordy; v = c_ovld; y = c_y;      c = 64'(c_cnt); end
    endcase
  endtask

  // Where each word would sit after the coming edge: the oldest leaves if it is at the
  // output and downstream is ready, otherwise moves up one stage but never into or past
  // the stage its older neighbour ends up in. Stage 0 is free to accept if no word remains there.
  task automatic plan(input int id);
    int lim;
    lim = dep[id];
    mv_pop = 0;
    for (int i = 0; i < m_n[id]; i++) begin
      if (i == 0 && m_pos[id][0] == dep[id] - 1 && rin[id]) begin
        mv_pop = 1;
        mv_pos[0] = dep[id];
      end else begin
        mv_pos[i] = (m_pos[id][i] + 1 < lim - 1) ? m_pos[id][i] + 1 : lim - 1;
        lim = mv_pos[i];
      end
    end
    if (m_n[id] == 0 || (m_n[id] == 1 && mv_pop)) m_ordy[id] = 1;
    else m_ordy[id] = (mv_pos[m_n[id]-1] > 0);
  endtask

  task automatic step(input int id);
    if (rst) begin
      m_n[id] = 0;
      m_y[id] = rval[id];
    end else if (fl[id]) begin
      m_n[id] = 0;
    end else begin
      int k;
      k = 0;
      for (int i = 0; i < m_n[id]; i++) begin
        if (!(i == 0 && mv_pop)) begin
          m_dat[id][k] = m_dat[id][i];
          m_pos[id][k] = mv_pos[i];
          k++;
        end
      end
      if (vin[id] && m_ordy[id]) begin
        m_dat[id][k] = xin[id] & wmask[id];
        m_pos[id][k] = 0;
        k++;
      end
      m_n[id] = k;
      for (int i = 0; i < k; i++) begin
        if (m_pos[id][i] == dep[id] - 1) m_y[id] = m_dat[id][i];
      end
    end
  endtask

  // Inputs are already set at the falling edge; check o_ready, run one rising edge, check outputs.
  task automatic tick();
    logic r, v;
    logic [63:0] y, c, exp_w;
    #1;
    for (int id = 0; id < 3; id++) begin
      plan(id);
      if (armed) begin
        get_out(id, r, v, y, c);
        chk($sformatf("ready%0d", id), 64'(r), 64'(m_ordy[id]));
        if (!rst && !fl[id] && id > 0) begin
          if (vin[id] && r) begin
            if (id == 1) sbq1.push_back(xin[id] & wmask[id]);
            else         sbq2.push_back(xin[id] & wmask[id]);
          end
          if (v && rin[id]) begin
            if (id == 1) exp_w = (sbq1.size() > 0) ? sbq1.pop_front() : 64'hx;
            else         exp_w = (sbq2.size() > 0) ? sbq2.pop_front() : 64'hx;
            chk($sformatf("order%0d", id), y, exp_w);
          end
        end
      end
      step(id);
    end
    @(posedge clk);
    #1;
    if (rst) armed = 1;
    if (armed) begin
      for (int id = 0; id < 3; id++) begin
        get_out(id, r, v, y, c);
        chk($sformatf("valid%0d", id), 64'(v),
            64'(m_n[id] > 0 && m_pos[id][0] == dep[id] - 1));
        chk($sformatf("count%0d", id), c, 64'(m_n[id]));
        chk($sformatf("y%0d", id), y, m_y[id]);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_a(input logic v, input logic [63:0] x, input logic r, input logic f);
    vin[0] = v;
    xin[0] = x;
    rin[0] = r;
    fl[0]  = f;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int id = 0; id < 3; id++) begin
      vin[id] = 0; rin[id] = 0; fl[id] = 0; xin[id] = '0; m_n[id] = 0; m_y[id] = '0;
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(a_ovld), 64'd0);
    chk("rst_count", 64'(a_cnt), 64'd0);
    chk("rst_y", 64'(a_y), 64'hDEADBEEF);
    chk("rst_ready", 64'(a_ordy), 64'd1);
    chk("rst_y_d1", 64'(b_y), 64'h5A5A);
    chk("rst_count_d8", 64'(c_cnt), 64'd0);

    // Stream with no backpressure.
    set_a(1, 64'h11, 1, 0); tick();
    chk("s_cnt1", 64'(a_cnt), 64'd1);
    chk("s_vld1", 64'(a_ovld), 64'd0);
    set_a(1, 64'h22, 1, 0); tick();
    chk("s_y11", 64'(a_y), 64'h11);
    chk("s_vld11", 64'(a_ovld), 64'd1);
    set_a(1, 64'h33, 1, 0); tick();
    chk("s_y22", 64'(a_y), 64'h22);
    chk("s_cnt2", 64'(a_cnt), 64'd2);
    set_a(0, 64'h0, 1, 0); tick();
    chk("s_y33", 64'(a_y), 64'h33);
    tick();
    chk("e_vld", 64'(a_ovld), 64'd0);
    chk("e_cnt", 64'(a_cnt), 64'd0);
    chk("e_y_hold", 64'(a_y), 64'h33);
    chk("e_ready", 64'(a_ordy), 64'd1);

    // Fill and stall.
    set_a(1, 64'hA, 0, 0); tick();
    set_a(1, 64'hB, 0, 0); tick();
    set_a(0, 64'h0, 0, 0);
    repeat (5) begin
      tick();
      chk("st_ready", 64'(a_ordy), 64'd0);
      chk("st_cnt", 64'(a_cnt), 64'd2);
      chk("st_y", 64'(a_y), 64'hA);
    end
    set_a(0, 64'h0, 1, 0); tick();
    chk("dr_yB", 64'(a_y), 64'hB);
    chk("dr_cnt", 64'(a_cnt), 64'd1);
    tick();
    chk("dr_vld", 64'(a_ovld), 64'd0);

    // Full pipe: one out, one in on the same edge.
    set_a(1, 64'hA, 0, 0); tick();
    set_a(1, 64'hB, 0, 0); tick();
    set_a(1, 64'hC, 1, 0);
    #1;
    chk("fx_ready", 64'(a_ordy), 64'd1);
    chk("fx_yA", 64'(a_y), 64'hA);
    tick();
    chk("fx_cnt", 64'(a_cnt), 64'd2);
    chk("fx_yB", 64'(a_y), 64'hB);

    // Flush with a word offered: nothing survives and 0xD never appears.
    set_a(1, 64'hD, 0, 1); tick();
    chk("fl_vld", 64'(a_ovld), 64'd0);
    chk("fl_cnt", 64'(a_cnt), 64'd0);
    set_a(0, 64'h0, 1, 0);
    repeat (4) begin
      tick();
      chk("fl_novld", 64'(a_ovld), 64'd0);
      chk("fl_y", 64'(a_y), 64'hB);
    end

    // Reset mid-stream wins over flush and accept.
    set_a(1, 64'h1, 1, 0); tick();
    set_a(1, 64'h2, 1, 0); tick();
    rst = 1'b1;
    set_a(1, 64'h5, 1, 1); tick();
    rst = 1'b0;
    chk("mr_y", 64'(a_y), 64'hDEADBEEF);
    chk("mr_vld", 64'(a_ovld), 64'd0);
    chk("mr_cnt", 64'(a_cnt), 64'd0);
    set_a(0, 64'h0, 0, 0);
    #1;
    chk("mr_ready", 64'(a_ordy), 64'd1);
    tick();

    // Random traffic on all three builds.
    for (int n = 0; n < 10000; n++) begin
      for (int id = 0; id < 3; id++) begin
        vin[id] = 1'($urandom_range(0, 1));
        rin[id] = 1'($urandom_range(0, 1));
        xin[id] = {$urandom, $urandom};
        fl[id]  = (id == 0) && ($urandom_range(0, 63) == 0);
      end
      tick();
    end
    for (int id = 0; id < 3; id++) begin
      vin[id] = 0; rin[id] = 1; fl[id] = 0;
    end
    repeat (12) tick();
    chk("sb_left1", 64'(sbq1.size()), 64'd0);
    chk("sb_left2", 64'(sbq2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nonarch_pipe_reg.md
NONARCH_PIPE_REG -- requirements
Module: nonarch_pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 2, number of register stages (1..8).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 Port i_clk  input  1  single clock; all state updates on posedge.
REQ-005 Port i_rst  input  1  synchronous, active-high reset.
REQ-006 Port i_flush  input  1  synchronous pipeline invalidate.
REQ-007 Port i_valid  input  1  upstream data valid.
REQ-008 Port o_ready  output  1  stage 0 can accept this cycle.
REQ-009 Port i_x  input  WIDTH  upstream data.
REQ-010 Port o_valid  output  1  last stage holds valid data.
REQ-011 Port i_ready  input  1  downstream accepts this cycle.
REQ-012 Port o_y  output  WIDTH  last-stage data, driven directly from a register.
REQ-013 Port o_count  output  $clog2(DEPTH+1)  number of stages currently valid.

Function
REQ-014 Block SHALL be a chain of DEPTH stages, each holding a WIDTH-bit data register and a 1-bit valid flag; stage 0 is fed by i_x, stage DEPTH-1 drives o_y/o_valid.
REQ-015 Transfer in: accept when i_valid && o_ready at the clock edge; transfer out: when o_valid && i_ready.
REQ-016 Stage k SHALL advance (data moves to k+1) when stage k valid and (stage k+1 invalid or stage k+1 advancing); last stage advances when i_ready.
REQ-017 o_ready SHALL equal (stage 0 invalid) or (stage 0 advancing); combinational path i_ready -> o_ready permitted; no other combinational path from inputs to outputs.
REQ-018 A stage not advancing and not loaded SHALL hold its data and valid unchanged (stall, bubble preservation).
REQ-019 Bubbles SHALL collapse: a valid stage advances into an invalid successor regardless of i_ready.
REQ-020 Latency: data accepted at edge N appears on o_y with o_valid=1 after edge N+DEPTH-1 when no backpressure; throughput one word per cycle sustained.
REQ-021 Order SHALL be preserved; no word duplicated or dropped except by flush/reset.
REQ-022 Full condition (all DEPTH stages valid, i_ready=0): o_ready=0, all stages hold.
REQ-023 Full with i_ready=1 and i_valid=1: one word out, one word in, same edge; o_count unchanged at DEPTH.
REQ-024 Empty condition: o_valid=0, o_count=0, o_ready=1; o_y holds last data value (not cleared).
REQ-025 i_flush=1: all valid flags cleared at the edge; data registers unchanged; input offered that cycle SHALL NOT be captured; output transfer that cycle SHALL NOT be counted as consumed by the block (downstream may sample it).
REQ-026 o_count SHALL be registered and equal the popcount of valid flags after every edge; never exceeds DEPTH.
REQ-027 DEPTH=1 SHALL behave as a single holding register with o_ready = !o_valid || i_ready.
REQ-028 Data SHALL NOT be modified arithmetically; widths match exactly, no truncation or extension.

Reset
REQ-029 i_rst=1 at an edge: all valid flags 0, all data = RESET_VAL, o_count=0; o_ready=1 in the following cycle.
REQ-030 Reset SHALL take priority over flush, accept and advance; in-flight words mid-operation are discarded.
REQ-031 Outputs are undefined only before the first reset edge.

Verification (WIDTH=32, DEPTH=2 unless noted)
REQ-032 Reset then stream 0x11,0x22,0x33 on consecutive cycles with i_ready=1 -> o_y=0x11 valid 1 cycle after accept edge, then 0x22, 0x33 back-to-back; o_count peaks at 2.
REQ-033 Fill with 0xA, 0xB, hold i_ready=0 five cycles -> o_ready=0, o_count=2, o_y=0xA stable; raise i_ready -> 0xA then 0xB delivered, no loss.
REQ-034 Full pipe, i_valid=1 with 0xC and i_ready=1 same cycle -> 0xA out, 0xC enters, o_count stays 2.
REQ-035 Two valid words in flight, assert i_flush one cycle with i_valid=1 (0xD) -> o_valid=0, o_count=0 next cycle, 0xD never appears.
REQ-036 Assert i_rst together with i_flush and i_valid mid-stream, RESET_VAL=0xDEADBEEF -> o_y=0xDEADBEEF, o_valid=0, o_count=0.
REQ-037 DEPTH=1 and DEPTH=8 builds: random i_valid/i_ready (50%) over 10000 cycles -> output sequence equals input sequence, o_count matches scoreboard every cycle.
